// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, matrix-to-code map and debounce FSM states
// shared by keypad_2bcd and keypad_debounce.
package keypad_pkg;

   localparam logic [3:0] KEY_OP_A  = 4'hA;
   localparam logic [3:0] KEY_OP_B  = 4'hB;
   localparam logic [3:0] KEY_OP_C  = 4'hC;
   localparam logic [3:0] KEY_OP_D  = 4'hD;
   localparam logic [3:0] KEY_CLEAR = 4'hE;
   localparam logic [3:0] KEY_ENTER = 4'hF;

   // Indexed by position col*4+row.
   // col0: 1 4 7 E, col1: 2 5 8 0, col2: 3 6 9 F, col3: A B C D
   localparam logic [15:0][3:0] KEY_MAP = {
      KEY_OP_D, KEY_OP_C, KEY_OP_B, KEY_OP_A,
      KEY_ENTER, 4'h9, 4'h6, 4'h3,
      4'h0, 4'h8, 4'h5, 4'h2,
      KEY_CLEAR, 4'h7, 4'h4, 4'h1
   };

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2
   } kp_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'h9;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-scan candidate comparison and IDLE/DEBOUNCE/PRESSED
// FSM. accept is a combinational pulse on the scan_done cycle that
// completes the debounce; the top registers the resulting event.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       scan_done,
   input  logic       cand_vld,
   input  logic [3:0] cand_pos,
   output logic       accept,
   output logic [3:0] acc_pos
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] DS_C = CW'(DEBOUNCE_SCANS);

   kp_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] rel_cnt, rel_cnt_n;
   logic [3:0]    prev_pos, prev_pos_n;

   // state and counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         rel_cnt  <= '0;
         prev_pos <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         rel_cnt  <= rel_cnt_n;
         prev_pos <= prev_pos_n;
      end
   end

   // next state: only evaluated at the end of a full scan
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      rel_cnt_n  = rel_cnt;
      prev_pos_n = prev_pos;
      accept     = 1'b0;
      acc_pos    = cand_pos;
      if (scan_done) begin
         case (state)
            ST_IDLE: begin
               if (cand_vld) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     accept    = 1'b1;
                     state_n   = ST_PRESSED;
                     rel_cnt_n = '0;
                  end else begin
                     state_n    = ST_DEBOUNCE;
                     cnt_n      = CW'(1);
                     prev_pos_n = cand_pos;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (!cand_vld) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else if (cand_pos == prev_pos) begin
                  if (cnt + 1'b1 == DS_C) begin
                     accept    = 1'b1;
                     state_n   = ST_PRESSED;
                     cnt_n     = '0;
                     rel_cnt_n = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n      = CW'(1);
                  prev_pos_n = cand_pos;
               end
            end
            ST_PRESSED: begin
               if (!cand_vld) begin
                  if (rel_cnt + 1'b1 == DS_C) begin
                     state_n   = ST_IDLE;
                     rel_cnt_n = '0;
                  end else begin
                     rel_cnt_n = rel_cnt + 1'b1;
                  end
               end else begin
                  rel_cnt_n = '0;
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               rel_cnt_n = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/keypad_2bcd.sv
// keypad_2bcd: 4x4 keypad scanner with debounce and 4-digit packed-BCD
// entry register. Define KEYPAD_ENTRY_LOCK_EN to stop digit entry once
// the register is full (digit 3 non-zero) instead of shifting digit 3 out.
module keypad_2bcd
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   output logic [3:0]  col_n,
   input  logic [3:0]  row_n,
   output logic [15:0] out_4bcd,
   output logic [3:0]  key_code,
   output logic        key_valid
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [3:0]    row_s1, row_s2;
   logic [DW-1:0] div_cnt;
   logic [1:0]    col;
   logic          hit_vld;
   logic [3:0]    hit_pos;
   logic          slot_end, scan_done;
   logic [3:0]    row_hit;
   logic          cur_any;
   logic [1:0]    cur_row;
   logic          cand_vld;
   logic [3:0]    cand_pos;
   logic          accept;
   logic [3:0]    acc_pos;
   logic [3:0]    acc_code;

   assign col_n     = ~(4'b0001 << col);
   assign slot_end  = en && (div_cnt == DIV_LAST);
   assign scan_done = slot_end && (col == 2'd3);
   assign row_hit   = ~row_s2;
   assign cur_any   = |row_hit;
   assign cand_vld  = hit_vld | cur_any;
   assign cand_pos  = hit_vld ? hit_pos : {col, cur_row};
   assign acc_code  = KEY_MAP[acc_pos];

   // two-flop synchronizer on the asynchronous row inputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   // lowest pressed row in the current column
   always_comb begin
      cur_row = 2'd0;
      for (int r = 3; r >= 0; r--)
         if (row_hit[r]) cur_row = 2'(r);
   end

   // column slot divider and column counter; both freeze while en is low
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt <= '0;
         col     <= 2'd0;
      end else if (slot_end) begin
         div_cnt <= '0;
         col     <= col + 2'd1;
      end else if (en) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // keep the first (lowest index) hit of the scan; columns go 0..3 so
   // the first column with a hit already holds the lowest position
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_vld <= 1'b0;
         hit_pos <= '0;
      end else if (scan_done) begin
         hit_vld <= 1'b0;
      end else if (slot_end && !hit_vld && cur_any) begin
         hit_vld <= 1'b1;
         hit_pos <= {col, cur_row};
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk       (clk),
      .resetn    (resetn),
      .scan_done (scan_done),
      .cand_vld  (cand_vld),
      .cand_pos  (cand_pos),
      .accept    (accept),
      .acc_pos   (acc_pos)
   );

   // key event and entry register update on an accepted key
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_valid <= 1'b0;
         key_code  <= '0;
         out_4bcd  <= '0;
      end else begin
         key_valid <= accept;
         if (accept) begin
            key_code <= acc_code;
            if (acc_code == KEY_CLEAR) begin
               out_4bcd <= '0;
            end else if (is_digit(acc_code)) begin
`ifdef KEYPAD_ENTRY_LOCK_EN
               if (out_4bcd[15:12] == 4'h0)
                  out_4bcd <= {out_4bcd[11:0], acc_code};
`else
               out_4bcd <= {out_4bcd[11:0], acc_code};
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_2bcd.sv
// tb_keypad_2bcd: directed table-driven bench for keypad_2bcd with a
// behavioural 4x4 key matrix on col_n/row_n.
module tb_keypad_2bcd;
   import keypad_pkg::*;

   localparam int SD   = 4;
   localparam int DS   = 3;
   localparam int SCAN = 4 * SD;
   localparam int NONE = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic [15:0] out_4bcd;
   logic [3:0]  key_code;
   logic        key_valid;

   logic [15:0] keys = '0;
   int          pulses = 0;
   int          total = 0;
   int          bad = 0;

   keypad_2bcd #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .en        (en),
      .col_n     (col_n),
      .row_n     (row_n),
      .out_4bcd  (out_4bcd),
      .key_code  (key_code),
      .key_valid (key_valid)
   );

   always #5 clk = ~clk;

   // key matrix: a pressed key pulls its row low while its column is driven
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
   end

   always @(negedge clk)
      if (key_valid) pulses++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      int          pos;
      int          pos2;
      int          hold;
      logic [3:0]  code;
      logic [15:0] exp_reg;
   } vec_t;

   vec_t tbl[9];

   task automatic run_vec(input int i);
      int p0;
      p0 = pulses;
      keys = '0;
      keys[tbl[i].pos] = 1'b1;
      if (tbl[i].pos2 != NONE) keys[tbl[i].pos2] = 1'b1;
      cyc(SCAN * tbl[i].hold);
      keys = '0;
      cyc(SCAN * 5);
      chk($sformatf("vec%0d pulses", i), pulses - p0, 1);
      chk($sformatf("vec%0d code", i), key_code, tbl[i].code);
      chk($sformatf("vec%0d reg", i), out_4bcd, tbl[i].exp_reg);
   endtask

   initial begin
      int          p0;
      logic [3:0]  col_hold;
      logic [3:0]  exp_col;

      //           pos  pos2  hold code   reg
      tbl[0] = '{0,  NONE, 5,  4'h1, 16'h0001};
      tbl[1] = '{4,  NONE, 5,  4'h2, 16'h0012};
      tbl[2] = '{8,  NONE, 5,  4'h3, 16'h0123};
      tbl[3] = '{1,  NONE, 5,  4'h4, 16'h1234};
`ifdef KEYPAD_ENTRY_LOCK_EN
      tbl[4] = '{5,  NONE, 5,  4'h5, 16'h1234};
`else
      tbl[4] = '{5,  NONE, 5,  4'h5, 16'h2345};
`endif
      tbl[5] = '{3,  NONE, 5,  4'hE, 16'h0000};
      tbl[6] = '{12, NONE, 5,  4'hA, 16'h0000};
      tbl[7] = '{2,  NONE, 20, 4'h7, 16'h0007};
      tbl[8] = '{2,  10,   5,  4'h7, 16'h0077};

      // reset values
      cyc(3);
      chk("rst col_n", col_n, 4'b1110);
      chk("rst out", out_4bcd, 16'h0);
      chk("rst code", key_code, 4'h0);
      chk("rst valid", key_valid, 1'b0);

      // idle column rotation
      resetn = 1'b1;
      en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         chk($sformatf("rotate k=%0d", k), col_n, exp_col);
      end
      cyc(SCAN);
      chk("idle pulses", pulses, 0);

      // digit entry 1..5
      for (int i = 0; i < 5; i++) run_vec(i);

      // bouncing 8, then stable
      p0 = pulses;
      for (int i = 0; i < 6; i++) begin
         keys = '0;
         keys[6] = (i % 2 == 0);
         cyc(SCAN);
      end
      keys = '0;
      keys[6] = 1'b1;
      cyc(SCAN * 3);
      keys = '0;
      cyc(SCAN * 5);
      chk("bounce pulses", pulses - p0, 1);
      chk("bounce code", key_code, 4'h8);
`ifdef KEYPAD_ENTRY_LOCK_EN
      chk("bounce reg", out_4bcd, 16'h1234);
`else
      chk("bounce reg", out_4bcd, 16'h3458);
`endif

      // clear, operator, long hold, two keys at once
      for (int i = 5; i < 9; i++) run_vec(i);

      // en low mid-debounce
      p0 = pulses;
      keys = '0;
      keys[9] = 1'b1;
      cyc(24);
      en = 1'b0;
      col_hold = col_n;
      for (int k = 0; k < 5; k++) begin
         cyc(10);
         chk($sformatf("en frz col k=%0d", k), col_n, col_hold);
      end
      chk("en frz pulses", pulses - p0, 0);
      en = 1'b1;
      cyc(SCAN * 5);
      keys = '0;
      cyc(SCAN * 5);
      chk("en resume pulses", pulses - p0, 1);
      chk("en resume code", key_code, 4'h6);
      chk("en resume reg", out_4bcd, 16'h0776);

      // reset mid-debounce with key held through release
      keys = '0;
      keys[4] = 1'b1;
      cyc(24);
      resetn = 1'b0;
      #1;
      chk("mid rst col_n", col_n, 4'b1110);
      chk("mid rst out", out_4bcd, 16'h0);
      chk("mid rst code", key_code, 4'h0);
      chk("mid rst valid", key_valid, 1'b0);
      cyc(2);
      resetn = 1'b1;
      p0 = pulses;
      cyc(SCAN * 2);
      chk("post rst early", pulses - p0, 0);
      cyc(SCAN * 3);
      chk("post rst pulses", pulses - p0, 1);
      chk("post rst code", key_code, 4'h2);
      chk("post rst reg", out_4bcd, 16'h0002);
      keys = '0;
      cyc(SCAN * 5);
      chk("final pulses", pulses - p0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
